// File: rtl/block_mem_pkg.sv
// block_mem_pkg: opcodes, controller states and the load-formatting helper shared with the AMO stage.
package block_mem_pkg;
  typedef enum logic [2:0] {e_nop, e_lw, e_lh, e_lhu, e_lb, e_lbu, e_store} block_mem_opcode_e;
  typedef enum logic {CLEAR, READY} block_mem_state_e;
  localparam int block_mem_opcode_width_lp = 3;
  // Nop and undefined opcodes format to zero so data_o reads 0 until the first load.
  function automatic logic [31:0] block_mem_load_format(input logic [31:0] word, input block_mem_opcode_e op, input logic [1:0] off);
    logic [15:0] h;
    logic [7:0] b;
    h = off[1] ? word[31:16] : word[15:0];
    b = word[{off, 3'b000}+:8];
    return op == e_lw  ? word
         : op == e_lh  ? {{16{h[15]}}, h}
         : op == e_lhu ? {16'h0, h}
         : op == e_lb  ? {{24{b[7]}}, b}
         : op == e_lbu ? {24'h0, b}
         : 32'h0;
  endfunction
endpackage

// File: rtl/bsg_mem_1rw_sync_mask_write_byte.sv
// bsg_mem_1rw_sync_mask_write_byte: single-port sync SRAM with byte write mask; read data holds when idle.
module bsg_mem_1rw_sync_mask_write_byte #(
  parameter int els_p = 1024,
  parameter int width_p = 32,
  localparam int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                     clk_i,
  input  logic                     v_i,
  input  logic                     w_i,
  input  logic [addr_width_lp-1:0] addr_i,
  input  logic [width_p-1:0]       data_i,
  input  logic [width_p/8-1:0]     write_mask_i,
  output logic [width_p-1:0]       data_o
);
  logic [width_p-1:0] mem [els_p];
  always_ff @(posedge clk_i) begin
    if (v_i & w_i)
      for (int i = 0; i < width_p/8; i++)
        if (write_mask_i[i]) mem[addr_i][8*i+:8] <= data_i[8*i+:8];
    if (v_i & ~w_i) data_o <= mem[addr_i];
  end
endmodule

// File: rtl/bsg_manycore_block_mem.sv
// bsg_manycore_block_mem: block memory executing one packet per cycle, with optional zero-fill after reset.
module bsg_manycore_block_mem
  import block_mem_pkg::*;
#(
  parameter int data_width_p = 32,
  parameter int mem_size_in_words_p = 1024,
  parameter bit clear_on_reset_p = 1'b1,
  localparam int ctr_width_lp = $clog2(mem_size_in_words_p),
  localparam int mem_addr_width_lp = ctr_width_lp + 2,
  localparam int block_mem_pkt_width_lp = block_mem_opcode_width_lp + mem_addr_width_lp + data_width_p + data_width_p/8
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic [block_mem_pkt_width_lp-1:0] pkt_i,
  input  logic                              v_i,
  output logic                              ready_o,
  output logic [data_width_p-1:0]           data_o,
  output logic                              data_v_o
);
  localparam int mask_w = data_width_p/8;
  block_mem_opcode_e op;
  logic [mem_addr_width_lp-1:0] addr;
  logic [data_width_p-1:0] pkt_data, mem_data;
  logic [mask_w-1:0] pkt_mask;
  block_mem_state_e state_r, state_n;
  logic [ctr_width_lp-1:0] clear_ctr_r;
  block_mem_opcode_e op_r;
  logic [1:0] off_r;
  logic clearing, accept, is_load, is_store, mem_v, mem_w;
  assign pkt_mask = pkt_i[mask_w-1:0];
  assign pkt_data = pkt_i[mask_w+:data_width_p];
  assign addr = pkt_i[mask_w+data_width_p+:mem_addr_width_lp];
  assign op = block_mem_opcode_e'(pkt_i[mask_w+data_width_p+mem_addr_width_lp+:block_mem_opcode_width_lp]);
  assign clearing = state_r == CLEAR;
  assign ready_o = state_r == READY;
  assign accept = v_i & ready_o;
  assign is_load = op inside {e_lw, e_lh, e_lhu, e_lb, e_lbu};
  assign is_store = op == e_store;
  assign mem_v = clearing | (accept & (is_load | is_store));
  assign mem_w = clearing | (accept & is_store);
  always_comb begin
    state_n = (clearing && clear_ctr_r == ctr_width_lp'(mem_size_in_words_p - 1)) ? READY : state_r;
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= clear_on_reset_p ? CLEAR : READY;
      clear_ctr_r <= '0;
    end else begin
      state_r <= state_n;
      if (clearing) clear_ctr_r <= clear_ctr_r + 1'b1;
    end
  end
  // Load context only moves on an accepted load so data_o holds across stores and nops.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      op_r <= e_nop;
      off_r <= 2'b00;
      data_v_o <= 1'b0;
    end else begin
      data_v_o <= accept & is_load;
      if (accept & is_load) begin
        op_r <= op;
        off_r <= addr[1:0];
      end
    end
  end
  bsg_mem_1rw_sync_mask_write_byte #(.els_p(mem_size_in_words_p), .width_p(data_width_p)) sram (
    .clk_i(clk_i),
    .v_i(mem_v),
    .w_i(mem_w),
    .addr_i(clearing ? clear_ctr_r : addr[mem_addr_width_lp-1:2]),
    .data_i(clearing ? '0 : pkt_data),
    .write_mask_i(clearing ? {mask_w{1'b1}} : pkt_mask),
    .data_o(mem_data)
  );
  assign data_o = block_mem_load_format(mem_data, op_r, off_r);
  assert property (@(posedge clk_i) disable iff (reset_i) !(v_i && clearing));
  assert property (@(posedge clk_i) disable iff (reset_i) (v_i && ready_o) |-> op <= e_store);
endmodule

// File: tb/tb_bsg_manycore_block_mem.sv
// tb_bsg_manycore_block_mem: directed checks of clear timing, masked stores, load formatting and output hold.
module tb_bsg_manycore_block_mem;
  import block_mem_pkg::*;
  logic clk_i = 1'b0;
  logic reset_i = 1'b1;
  logic [50:0] pkt_i = '0;
  logic v_i = 1'b0;
  logic ready_o, data_v_o;
  logic [31:0] data_o;
  int checks = 0;
  int errors = 0;
  bsg_manycore_block_mem #(.data_width_p(32), .mem_size_in_words_p(1024), .clear_on_reset_p(1'b1)) dut (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .pkt_i(pkt_i),
    .v_i(v_i),
    .ready_o(ready_o),
    .data_o(data_o),
    .data_v_o(data_v_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, act, exp);
    end
  endtask
  task automatic send(input block_mem_opcode_e op, input logic [11:0] a, input logic [31:0] d, input logic [3:0] m);
    pkt_i = {op, a, d, m};
    v_i = 1'b1;
    @(posedge clk_i);
    #1;
    v_i = 1'b0;
    pkt_i = '0;
  endtask
  task automatic load(input string tag, input block_mem_opcode_e op, input logic [11:0] a, input logic [31:0] exp);
    send(op, a, 32'h0, 4'h0);
    chk(tag, data_o, exp);
    chk({tag, "_v"}, {31'h0, data_v_o}, 32'h1);
  endtask
  task automatic wait_clear(input string tag);
    int n;
    int bad;
    n = 0;
    bad = 0;
    while (!ready_o && n < 2000) begin
      @(posedge clk_i);
      #1;
      n++;
      if (data_o !== 32'h0) bad++;
    end
    chk({tag, "_cycles"}, n, 1024);
    chk({tag, "_data_zero"}, bad, 0);
  endtask
  initial begin
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_ready", {31'h0, ready_o}, 32'h0);
    chk("rst_data", data_o, 32'h0);
    chk("rst_data_v", {31'h0, data_v_o}, 32'h0);
    @(negedge clk_i);
    reset_i = 1'b0;
    wait_clear("clear1");
    load("lw0_clr", e_lw, 12'h000, 32'h0);
    load("lw_last_clr", e_lw, 12'hFFC, 32'h0);
    send(e_store, 12'h010, 32'hDEADBEEF, 4'hF);
    chk("store_no_v", {31'h0, data_v_o}, 32'h0);
    load("lw_10", e_lw, 12'h010, 32'hDEADBEEF);
    send(e_nop, 12'h0, 32'h0, 4'h0);
    chk("nop_v_low", {31'h0, data_v_o}, 32'h0);
    chk("nop_hold", data_o, 32'hDEADBEEF);
    send(e_store, 12'h010, 32'h000000AA, 4'b0001);
    load("lw_masked", e_lw, 12'h010, 32'hDEADBEAA);
    load("lb_13", e_lb, 12'h013, 32'hFFFFFFDE);
    load("lbu_13", e_lbu, 12'h013, 32'h000000DE);
    send(e_store, 12'h010, 32'h12345678, 4'h0);
    load("mask0_noop", e_lw, 12'h010, 32'hDEADBEAA);
    send(e_store, 12'h020, 32'h80017FFF, 4'hF);
    load("lh_20", e_lh, 12'h020, 32'h00007FFF);
    load("lh_22", e_lh, 12'h022, 32'hFFFF8001);
    load("lhu_23", e_lhu, 12'h023, 32'h00008001);
    load("lh_21", e_lh, 12'h021, 32'h00007FFF);
    load("lb_21", e_lb, 12'h021, 32'h0000007F);
    load("lbu_22", e_lbu, 12'h022, 32'h00000001);
    load("lw_23", e_lw, 12'h023, 32'h80017FFF);
    load("lw_hold_src", e_lw, 12'h020, 32'h80017FFF);
    send(e_store, 12'h030, 32'h12345678, 4'hF);
    chk("hold_store", data_o, 32'h80017FFF);
    send(e_nop, 12'h0, 32'h0, 4'h0);
    chk("hold_nop1", data_o, 32'h80017FFF);
    send(e_nop, 12'h0, 32'h0, 4'h0);
    chk("hold_nop2", data_o, 32'h80017FFF);
    send(e_store, 12'h020, 32'hCAFEF00D, 4'hF);
    load("raw_b2b", e_lw, 12'h020, 32'hCAFEF00D);
    load("lw_30", e_lw, 12'h030, 32'h12345678);
    reset_i = 1'b1;
    #1;
    chk("rst2_ready", {31'h0, ready_o}, 32'h0);
    chk("rst2_data", data_o, 32'h0);
    @(negedge clk_i);
    reset_i = 1'b0;
    repeat (500) @(posedge clk_i);
    #1;
    chk("midclear_ready", {31'h0, ready_o}, 32'h0);
    reset_i = 1'b1;
    #1;
    chk("rst3_data", data_o, 32'h0);
    @(negedge clk_i);
    reset_i = 1'b0;
    wait_clear("clear_restart");
    load("lw_30_clr", e_lw, 12'h030, 32'h0);
    load("lw_20_clr", e_lw, 12'h020, 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
